// File: rtl/decoder_pkg.sv
// decoder_pkg: shared skid-buffer state encoding and error-counter width for decoder_pipe
package decoder_pkg;
    typedef enum logic [1:0] {EMPTY, ONE, FULL} skid_state_t;
    localparam int ERRCNT_W = 16;
endpackage

// File: rtl/decoder_onehot.sv
// decoder_onehot: combinational binary-to-one-hot decoder; codes >= OUTS raise err with no line active
module decoder_onehot #(
    parameter int BITS       = 5,
    parameter int OUTS       = 32,
    parameter int ACTIVE_LOW = 0
) (
    input  logic [BITS-1:0] code,
    output logic [OUTS-1:0] onehot,
    output logic            err
);
    localparam logic [BITS:0] LIMIT = (BITS+1)'(OUTS);
    logic [OUTS-1:0] hot;
    genvar i;
    for (i = 0; i < OUTS; i++) begin : g_line
        assign hot[i] = code == BITS'(i);
    end
    assign err    = {1'b0, code} >= LIMIT;
    assign onehot = ACTIVE_LOW != 0 ? ~hot : hot;
endmodule

// File: rtl/decoder_pipe.sv
// decoder_pipe: valid/ready decoder behind a 2-entry skid buffer with registered in_ready
// Define DECODER_PIPE_ERRCNT_EN to enable the saturating count of consumed error beats.
module decoder_pipe
    import decoder_pkg::*;
#(
    parameter int BITS       = 5,
    parameter int OUTS       = 32,
    parameter int ACTIVE_LOW = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [BITS-1:0]     code_in,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [OUTS-1:0]     code_out,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_err,
    output logic [ERRCNT_W-1:0] err_count
);
    localparam logic [OUTS-1:0] IDLE = {OUTS{ACTIVE_LOW != 0}};
    skid_state_t state, state_nx;
    logic [OUTS-1:0] dec_hot, head_hot, skid_hot;
    logic dec_err, head_err, skid_err, accept, consume;
    decoder_onehot #(.BITS(BITS), .OUTS(OUTS), .ACTIVE_LOW(ACTIVE_LOW)) u_dec (
        .code(code_in),
        .onehot(dec_hot),
        .err(dec_err)
    );
    assign accept    = in_valid && in_ready;
    assign consume   = out_valid && out_ready;
    assign out_valid = state != EMPTY;
    assign code_out  = out_valid ? head_hot : IDLE;
    assign out_err   = out_valid && head_err;
    always_comb begin
        state_nx = state == EMPTY ? (accept ? ONE : EMPTY)
                 : state == ONE   ? (accept && !consume ? FULL : !accept && consume ? EMPTY : ONE)
                 : (consume ? ONE : FULL);
    end
    // in_ready follows the next state so it never depends combinationally on out_ready
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= EMPTY;
            in_ready <= 1'b0;
        end else begin
            state    <= state_nx;
            in_ready <= state_nx != FULL;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_hot <= IDLE;
            head_err <= 1'b0;
            skid_hot <= IDLE;
            skid_err <= 1'b0;
        end else begin
            if ((state == EMPTY && accept) || (state == ONE && accept && consume)) begin
                head_hot <= dec_hot;
                head_err <= dec_err;
            end else if (state == FULL && consume) begin
                head_hot <= skid_hot;
                head_err <= skid_err;
            end
            if (state == ONE && accept && !consume) begin
                skid_hot <= dec_hot;
                skid_err <= dec_err;
            end
        end
    end
`ifdef DECODER_PIPE_ERRCNT_EN
    logic [ERRCNT_W-1:0] cnt;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt <= '0;
        else if (consume && out_err && cnt != '1) cnt <= cnt + 1'b1;
    end
    assign err_count = cnt;
`else
    assign err_count = '0;
`endif
endmodule

// File: tb/tb_decoder_pipe.sv
// tb_decoder_pipe: directed table-driven bench for decoder_pipe in three parameterisations
module tb_decoder_pipe;
    typedef struct {
        logic [4:0]  code;
        logic [31:0] exp_out;
        logic        exp_err;
    } vec_t;

`ifdef DECODER_PIPE_ERRCNT_EN
    localparam logic [15:0] EXP_CNT = 16'd2;
`else
    localparam logic [15:0] EXP_CNT = 16'd0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [4:0]  a_code;
    logic        a_iv, a_ir, a_ov, a_or, a_err;
    logic [31:0] a_out;
    logic [15:0] a_cnt;
    logic [2:0]  b_code;
    logic        b_iv, b_ir, b_ov, b_or, b_err;
    logic [4:0]  b_out;
    logic [15:0] b_cnt;
    logic [4:0]  c_code;
    logic        c_iv, c_ir, c_ov, c_or, c_err;
    logic [31:0] c_out;
    logic [15:0] c_cnt;

    int checks = 0;
    int errors = 0;
    vec_t va[32];
    vec_t vb[3];

    decoder_pipe dut_a (
        .clk(clk), .rst(rst), .code_in(a_code), .in_valid(a_iv), .in_ready(a_ir),
        .code_out(a_out), .out_valid(a_ov), .out_ready(a_or), .out_err(a_err), .err_count(a_cnt)
    );
    decoder_pipe #(.BITS(3), .OUTS(5)) dut_b (
        .clk(clk), .rst(rst), .code_in(b_code), .in_valid(b_iv), .in_ready(b_ir),
        .code_out(b_out), .out_valid(b_ov), .out_ready(b_or), .out_err(b_err), .err_count(b_cnt)
    );
    decoder_pipe #(.ACTIVE_LOW(1)) dut_c (
        .clk(clk), .rst(rst), .code_in(c_code), .in_valid(c_iv), .in_ready(c_ir),
        .code_out(c_out), .out_valid(c_ov), .out_ready(c_or), .out_err(c_err), .err_count(c_cnt)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            va[i].code    = 5'(i);
            va[i].exp_out = 32'd1 << i;
            va[i].exp_err = 1'b0;
        end
        vb[0].code = 5'd4; vb[0].exp_out = 32'h10; vb[0].exp_err = 1'b0;
        vb[1].code = 5'd5; vb[1].exp_out = 32'h00; vb[1].exp_err = 1'b1;
        vb[2].code = 5'd7; vb[2].exp_out = 32'h00; vb[2].exp_err = 1'b1;
        {a_code, a_iv, a_or} = '0;
        {b_code, b_iv, b_or} = '0;
        {c_code, c_iv, c_or} = '0;
        #12;
        chk("rst_out_valid", 64'(a_ov), 64'd0);
        chk("rst_in_ready", 64'(a_ir), 64'd0);
        chk("rst_code_out", 64'(a_out), 64'd0);
        chk("rst_out_err", 64'(a_err), 64'd0);
        chk("rst_err_count", 64'(b_cnt), 64'd0);
        chk("rst_code_out_low", 64'(c_out), 64'hFFFF_FFFF);
        @(posedge clk);
        #1 rst = 1'b0;
        chk("in_ready_before_edge", 64'(a_ir), 64'd0);
        step();
        chk("in_ready_after_edge", 64'(a_ir), 64'd1);

        a_or = 1'b1;
        for (int i = 0; i < 32; i++) begin
            a_iv = 1'b1;
            a_code = va[i].code;
            step();
            chk($sformatf("stream_valid_%0d", i), 64'(a_ov), 64'd1);
            chk($sformatf("stream_out_%0d", i), 64'(a_out), 64'(va[i].exp_out));
            chk($sformatf("stream_err_%0d", i), 64'(a_err), 64'(va[i].exp_err));
            chk($sformatf("stream_ready_%0d", i), 64'(a_ir), 64'd1);
        end
        a_iv = 1'b0;
        step();
        chk("stream_idle_valid", 64'(a_ov), 64'd0);
        chk("stream_idle_out", 64'(a_out), 64'd0);

        b_or = 1'b1;
        for (int i = 0; i < 3; i++) begin
            b_iv = 1'b1;
            b_code = 3'(vb[i].code);
            step();
            chk($sformatf("small_valid_%0d", i), 64'(b_ov), 64'd1);
            chk($sformatf("small_out_%0d", i), 64'(b_out), 64'(vb[i].exp_out));
            chk($sformatf("small_err_%0d", i), 64'(b_err), 64'(vb[i].exp_err));
        end
        b_iv = 1'b0;
        step();
        chk("small_idle_out", 64'(b_out), 64'd0);
        chk("small_idle_err", 64'(b_err), 64'd0);
        chk("small_err_count", 64'(b_cnt), 64'(EXP_CNT));

        c_or = 1'b1;
        chk("low_idle", 64'(c_out), 64'hFFFF_FFFF);
        c_iv = 1'b1;
        c_code = 5'd0;
        step();
        c_iv = 1'b0;
        chk("low_code0", 64'(c_out), 64'hFFFF_FFFE);
        step();
        chk("low_idle_after", 64'(c_out), 64'hFFFF_FFFF);

        a_or = 1'b0;
        a_iv = 1'b1;
        a_code = 5'd1;
        step();
        chk("bp_first_out", 64'(a_out), 64'h2);
        chk("bp_first_ready", 64'(a_ir), 64'd1);
        a_code = 5'd2;
        step();
        chk("bp_full_ready", 64'(a_ir), 64'd0);
        chk("bp_hold_out", 64'(a_out), 64'h2);
        a_code = 5'd3;
        step();
        chk("bp_blocked_ready", 64'(a_ir), 64'd0);
        chk("bp_blocked_out", 64'(a_out), 64'h2);
        chk("bp_blocked_valid", 64'(a_ov), 64'd1);
        a_or = 1'b1;
        step();
        chk("bp_second_out", 64'(a_out), 64'h4);
        chk("bp_ready_back", 64'(a_ir), 64'd1);
        step();
        a_iv = 1'b0;
        chk("bp_third_out", 64'(a_out), 64'h8);
        step();
        chk("bp_drained", 64'(a_ov), 64'd0);

`ifdef DECODER_PIPE_ERRCNT_EN
        b_iv = 1'b1;
        b_code = 3'd7;
        repeat (65537) step();
        b_iv = 1'b0;
        step();
        chk("err_count_saturated", 64'(b_cnt), 64'hFFFF);
`endif

        a_or = 1'b0;
        a_iv = 1'b1;
        a_code = 5'd5;
        step();
        a_code = 5'd6;
        step();
        a_iv = 1'b0;
        chk("rst_mid_full", 64'(a_ir), 64'd0);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_valid", 64'(a_ov), 64'd0);
        chk("rst_mid_out", 64'(a_out), 64'd0);
        chk("rst_mid_ready", 64'(a_ir), 64'd0);
        chk("rst_mid_err_count", 64'(b_cnt), 64'd0);
        step();
        step();
        rst = 1'b0;
        a_or = 1'b1;
        chk("rst_rel_ready_low", 64'(a_ir), 64'd0);
        step();
        chk("rst_rel_ready_high", 64'(a_ir), 64'd1);
        chk("rst_rel_no_beat", 64'(a_ov), 64'd0);
        step();
        chk("rst_rel_still_empty", 64'(a_ov), 64'd0);
        chk("rst_rel_out", 64'(a_out), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
